// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared raster constants, coordinate type, FSM states and sprite address helper
package sprite_pkg;

    localparam int SCREEN_W = 128;
    localparam int SCREEN_H = 96;

    typedef logic [6:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SCAN   = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    // Bitmap word index inside the sprite, row-major over the latched width.
    function automatic logic [13:0] sprite_offset(input coord_t dx, input coord_t dy, input coord_t w);
        logic [13:0] prod;
        prod = 14'(dy) * 14'(w);
        return prod + 14'(dx);
    endfunction

endpackage

// File: rtl/sprite_scan_renderer_raster_counter.sv
// rtl/sprite_scan_renderer_raster_counter.sv - pixel prescaler plus h/v slot counters for the scan raster
module raster_counter #(
    parameter int PIX_DIV = 4,
    parameter int H_TOTAL = 160,
    parameter int V_TOTAL = 104
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    output logic       o_pe,
    output logic       o_line_end,
    output logic       o_frame_end,
    output logic [7:0] o_h,
    output logic [6:0] o_v
);

    localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [7:0]    r_h;
    logic [6:0]    r_v;
    logic          w_pe;
    logic          w_line_end;
    logic          w_frame_end;

    assign w_pe        = i_run && (r_presc == PW'(PIX_DIV - 1));
    assign w_line_end  = w_pe && (r_h == 8'(H_TOTAL - 1));
    assign w_frame_end = w_line_end && (r_v == 7'(V_TOTAL - 1));

    // Counters sit at zero whenever the scan is not running so every frame starts at (0,0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_h     <= '0;
            r_v     <= '0;
        end else if (!i_run) begin
            r_presc <= '0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_presc <= w_pe ? '0 : r_presc + 1'b1;
            if (w_pe) begin
                if (w_line_end) begin
                    r_h <= '0;
                    r_v <= w_frame_end ? '0 : r_v + 7'd1;
                end else begin
                    r_h <= r_h + 8'd1;
                end
            end
        end
    end

    assign o_pe        = w_pe;
    assign o_line_end  = w_line_end;
    assign o_frame_end = w_frame_end;
    assign o_h         = r_h;
    assign o_v         = r_v;

endmodule

// File: rtl/sprite_scan_renderer.sv
// rtl/sprite_scan_renderer.sv - raster walker with per-frame sprite snapshot and hit/address pipeline
// Optional toroidal sprite placement: define SPRITE_WRAP_EN.
module sprite_scan_renderer
    import sprite_pkg::*;
#(
    parameter int H_BLANK = 32,
    parameter int V_BLANK = 8,
    parameter int PIX_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [6:0]  i_x_pos,
    input  logic [6:0]  i_y_pos,
    input  logic [6:0]  i_width,
    input  logic [6:0]  i_height,
    output logic [6:0]  o_pix_x,
    output logic [6:0]  o_pix_y,
    output logic        o_pix_valid,
    output logic        o_sprite_hit,
    output logic [13:0] o_sprite_addr,
    output logic        o_frame_tick
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_frame_tick;
    logic        w_run;
    logic        w_scan;

    logic        w_pe;
    logic        w_line_end;
    logic        w_frame_end;
    logic [7:0]  w_h;
    logic [6:0]  w_v;

    coord_t      r_x_l;
    coord_t      r_y_l;
    coord_t      r_w_l;
    coord_t      r_h_l;

    logic        w_hit;
    coord_t      w_dx;
    coord_t      w_dy;
    logic [13:0] w_addr;

    coord_t      r_pix_x;
    coord_t      r_pix_y;
    logic        r_pix_valid;
    logic        r_sprite_hit;
    logic [13:0] r_sprite_addr;

    raster_counter #(
        .PIX_DIV (PIX_DIV),
        .H_TOTAL (SCREEN_W + H_BLANK),
        .V_TOTAL (SCREEN_H + V_BLANK)
    ) u_raster (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (w_run),
        .o_pe        (w_pe),
        .o_line_end  (w_line_end),
        .o_frame_end (w_frame_end),
        .o_h         (w_h),
        .o_v         (w_v)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!i_enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_next_state = ST_LATCH;
                ST_LATCH:  w_next_state = ST_SCAN;
                ST_SCAN: begin
                    if (w_frame_end) begin
                        w_next_state = ST_LATCH;
                    end else if (w_line_end && (w_v == 7'(SCREEN_H - 1))) begin
                        w_next_state = ST_VBLANK;
                    end
                end
                ST_VBLANK: if (w_frame_end) w_next_state = ST_LATCH;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_frame_tick = (r_state == ST_LATCH);
        w_scan       = (r_state == ST_SCAN);
        w_run        = i_enable && ((r_state == ST_SCAN) || (r_state == ST_VBLANK));
    end

    // Snapshot once per frame so a mid-frame position update cannot tear the sprite.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x_l <= '0;
            r_y_l <= '0;
            r_w_l <= '0;
            r_h_l <= '0;
        end else if (r_state == ST_LATCH) begin
            r_x_l <= i_x_pos;
            r_y_l <= i_y_pos;
            r_w_l <= i_width;
            r_h_l <= i_height;
        end
    end

`ifdef SPRITE_WRAP_EN
    logic [7:0] w_dy8;
    always_comb begin
        w_dx  = w_h[6:0] - r_x_l;
        w_dy8 = {1'b0, w_v} - {1'b0, r_y_l};
        if (w_v < r_y_l) begin
            w_dy8 = w_dy8 + 8'(SCREEN_H);
        end
        w_dy  = w_dy8[6:0];
        w_hit = !w_h[7] && (w_dx < r_w_l) && (w_dy8 < {1'b0, r_h_l});
    end
`else
    logic [7:0] w_x_end;
    logic [7:0] w_y_end;
    always_comb begin
        w_x_end = {1'b0, r_x_l} + {1'b0, r_w_l};
        w_y_end = {1'b0, r_y_l} + {1'b0, r_h_l};
        w_dx    = w_h[6:0] - r_x_l;
        w_dy    = w_v - r_y_l;
        w_hit   = (w_h >= {1'b0, r_x_l}) && (w_h < w_x_end) &&
                  ({1'b0, w_v} >= {1'b0, r_y_l}) && ({1'b0, w_v} < w_y_end);
    end
`endif

    assign w_addr = w_hit ? sprite_offset(w_dx, w_dy, r_w_l) : 14'd0;

    // Coordinates, hit and address hold between slots; only the valid strobe self-clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_valid   <= 1'b0;
            r_sprite_hit  <= 1'b0;
            r_sprite_addr <= '0;
        end else if (!i_enable) begin
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_valid   <= 1'b0;
            r_sprite_hit  <= 1'b0;
            r_sprite_addr <= '0;
        end else begin
            r_pix_valid <= 1'b0;
            if (w_scan && w_pe && (w_h < 8'(SCREEN_W))) begin
                r_pix_x       <= w_h[6:0];
                r_pix_y       <= w_v;
                r_pix_valid   <= 1'b1;
                r_sprite_hit  <= w_hit;
                r_sprite_addr <= w_addr;
            end
        end
    end

    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_pix_valid   = r_pix_valid;
    assign o_sprite_hit  = r_sprite_hit;
    assign o_sprite_addr = r_sprite_addr;
    assign o_frame_tick  = w_frame_tick;

endmodule

// File: tb/tb_sprite_scan_renderer.sv
// tb/tb_sprite_scan_renderer.sv - directed vector bench for sprite_scan_renderer
module tb_sprite_scan_renderer;

    localparam int PIX_DIV = 2;
    localparam int H_BLANK = 4;
    localparam int V_BLANK = 2;
    localparam int FRAME   = 1 + PIX_DIV * (128 + H_BLANK) * (96 + V_BLANK);
    localparam int NVEC    = 7;

    typedef struct {
        int x; int y; int w; int h; int stop_row;
        int hits; int fx; int fy; int fa; int lx; int ly; int la;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [6:0]  x_in, y_in, w_in, h_in;
    logic [6:0]  o_pix_x, o_pix_y;
    logic        o_pix_valid, o_sprite_hit, o_frame_tick;
    logic [13:0] o_sprite_addr;

    int checks = 0;
    int failures = 0;

    int a_x, a_y, a_w, a_h;
    bit latch_pending = 0;
    bit prev_valid = 0;
    int seg_cyc, seg_valid, seg_hits, seg_bad, seg_timeout, first_cyc;
    int fv_x, fv_y, f_x, f_y, f_a, l_x, l_y, l_a;
    int bad;
    vec_t vecs[NVEC];

    sprite_scan_renderer #(
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK),
        .PIX_DIV (PIX_DIV)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_x_pos       (x_in),
        .i_y_pos       (y_in),
        .i_width       (w_in),
        .i_height      (h_in),
        .o_pix_x       (o_pix_x),
        .o_pix_y       (o_pix_y),
        .o_pix_valid   (o_pix_valid),
        .o_sprite_hit  (o_sprite_hit),
        .o_sprite_addr (o_sprite_addr),
        .o_frame_tick  (o_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input int px, input int py, output int addr);
        int dx, dy;
        bit hit;
`ifdef SPRITE_WRAP_EN
        dx = ((px - a_x) % 128 + 128) % 128;
        dy = py - a_y;
        if (dy < 0) dy += 96;
        hit = (dy >= 0) && (dx < a_w) && (dy < a_h);
`else
        dx = px - a_x;
        dy = py - a_y;
        hit = (dx >= 0) && (dx < a_w) && (dy >= 0) && (dy < a_h);
`endif
        addr = hit ? dy * a_w + dx : 0;
        return hit;
    endfunction

    task automatic seg_clear();
        seg_cyc = 0; seg_valid = 0; seg_hits = 0; seg_bad = 0; seg_timeout = 0;
        first_cyc = -1; fv_x = -1; fv_y = -1;
        f_x = -1; f_y = -1; f_a = -1; l_x = -1; l_y = -1; l_a = -1;
        prev_valid = 0;
    endtask

    // Runs until pixel (sx,sy) is strobed, or until the next frame_tick when to_tick is set.
    task automatic watch(input int sx, input int sy, input bit to_tick, input int budget);
        bit done;
        bit eh;
        int ea;
        int n;
        done = 0;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
            seg_cyc++;
            if (latch_pending) begin
                a_x = x_in; a_y = y_in; a_w = w_in; a_h = h_in;
                latch_pending = 0;
            end
            if (o_frame_tick) begin
                latch_pending = 1;
                if (to_tick) done = 1;
            end
            if (o_pix_valid) begin
                seg_valid++;
                if (first_cyc < 0) begin
                    first_cyc = seg_cyc; fv_x = o_pix_x; fv_y = o_pix_y;
                end
                if (prev_valid) seg_bad++;
                eh = model_hit(o_pix_x, o_pix_y, ea);
                if (eh != o_sprite_hit || ea != int'(o_sprite_addr)) seg_bad++;
                if (o_sprite_hit) begin
                    seg_hits++;
                    if (f_x < 0) begin
                        f_x = o_pix_x; f_y = o_pix_y; f_a = o_sprite_addr;
                    end
                    l_x = o_pix_x; l_y = o_pix_y; l_a = o_sprite_addr;
                end
                if (!to_tick && o_pix_x == sx && o_pix_y == sy) done = 1;
            end
            prev_valid = o_pix_valid;
        end
        if (!done) seg_timeout++;
    endtask

    task automatic restart(input string name);
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        chk(name, o_frame_tick, 1);
        latch_pending = 1;
    endtask

    initial begin
`ifdef SPRITE_WRAP_EN
        vecs[0] = '{126, 0, 4, 1, 0,   4,   0, 0, 2, 127, 0, 1};
        vecs[4] = '{127, 3, 127, 2, 5, 254, 0, 3, 1, 127, 4, 127};
`else
        vecs[0] = '{126, 0, 4, 1, 0,   2, 126, 0, 0, 127, 0, 1};
        vecs[4] = '{127, 3, 127, 2, 5,   2, 127, 3, 0, 127, 4, 127};
`endif
        vecs[1] = '{0, 0, 0, 5, 5,     0, -1, -1, -1, -1, -1, -1};
        vecs[2] = '{5, 2, 3, 0, 3,     0, -1, -1, -1, -1, -1, -1};
        vecs[3] = '{0, 0, 1, 1, 1,     1, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{3, 1, 2, 2, 3,     4, 3, 1, 0, 4, 2, 3};
        vecs[6] = '{0, 0, 127, 127, 0, 127, 0, 0, 0, 126, 0, 126};

        rst_n = 1'b0; enable = 1'b1;
        x_in = 7'd40; y_in = 7'd40; w_in = 7'd0; h_in = 7'd10;
        a_x = 0; a_y = 0; a_w = 0; a_h = 0;
        seg_clear();

        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (o_pix_x != 0 || o_pix_y != 0 || o_pix_valid || o_sprite_hit ||
                o_sprite_addr != 0 || o_frame_tick) bad++;
        end
        chk("reset_outputs", bad, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tick_after_reset", o_frame_tick, 1);
        latch_pending = 1;

        // Frame 1: zero width, full-frame period and pixel count
        seg_clear();
        watch(0, 0, 1, FRAME + 100);
        chk("f1_first_valid_latency", first_cyc, PIX_DIV + 1);
        chk("f1_first_pix_x", fv_x, 0);
        chk("f1_first_pix_y", fv_y, 0);
        chk("f1_tick_spacing", seg_cyc, FRAME);
        chk("f1_valid_count", seg_valid, 128 * 96);
        chk("f1_hits_w0", seg_hits, 0);
        chk("f1_pixel_model", seg_bad, 0);
        chk("f1_timeout", seg_timeout, 0);

        // Frame 2: x=10 latched, x moved to 50 mid-frame must not show yet
        x_in = 7'd10; y_in = 7'd20; w_in = 7'd4; h_in = 7'd3;
        seg_clear();
        watch(0, 16, 0, FRAME);
        x_in = 7'd50;
        watch(0, 0, 1, FRAME);
        chk("f2_hits", seg_hits, 12);
        chk("f2_first_x", f_x, 10);
        chk("f2_first_y", f_y, 20);
        chk("f2_first_addr", f_a, 0);
        chk("f2_last_x", l_x, 13);
        chk("f2_last_y", l_y, 22);
        chk("f2_last_addr", l_a, 11);
        chk("f2_pixel_model", seg_bad, 0);
        chk("f2_timeout", seg_timeout, 0);

        // Frame 3: the x=50 update takes effect
        seg_clear();
        watch(51, 20, 0, FRAME);
        chk("f3_hits", seg_hits, 2);
        chk("f3_first_x", f_x, 50);
        chk("f3_last_x", l_x, 51);
        chk("f3_last_addr", l_a, 1);
        chk("f3_pixel_model", seg_bad, 0);
        chk("f3_timeout", seg_timeout, 0);

        // Drop enable mid-line right after a hit pixel
        enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_pix_x", o_pix_x, 0);
        chk("dis_pix_y", o_pix_y, 0);
        chk("dis_hit", o_sprite_hit, 0);
        chk("dis_addr", o_sprite_addr, 0);
        chk("dis_valid", o_pix_valid, 0);
        chk("dis_tick", o_frame_tick, 0);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_pix_valid || o_frame_tick || o_pix_x != 0 || o_sprite_hit) bad++;
        end
        chk("idle_quiet", bad, 0);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("reenable_tick", o_frame_tick, 1);
        latch_pending = 1;
        seg_clear();
        watch(0, 0, 0, 50);
        chk("reenable_first_latency", first_cyc, PIX_DIV + 1);
        chk("reenable_first_x", fv_x, 0);
        chk("reenable_first_y", fv_y, 0);
        chk("reenable_timeout", seg_timeout, 0);

        for (int i = 0; i < NVEC; i++) begin
            x_in = 7'(vecs[i].x); y_in = 7'(vecs[i].y);
            w_in = 7'(vecs[i].w); h_in = 7'(vecs[i].h);
            restart($sformatf("v%0d_tick", i));
            seg_clear();
            watch(127, vecs[i].stop_row, 0, FRAME);
            chk($sformatf("v%0d_hits", i), seg_hits, vecs[i].hits);
            chk($sformatf("v%0d_first_x", i), f_x, vecs[i].fx);
            chk($sformatf("v%0d_first_y", i), f_y, vecs[i].fy);
            chk($sformatf("v%0d_first_addr", i), f_a, vecs[i].fa);
            chk($sformatf("v%0d_last_x", i), l_x, vecs[i].lx);
            chk($sformatf("v%0d_last_y", i), l_y, vecs[i].ly);
            chk($sformatf("v%0d_last_addr", i), l_a, vecs[i].la);
            chk($sformatf("v%0d_pixel_model", i), seg_bad, 0);
            chk($sformatf("v%0d_timeout", i), seg_timeout, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
